// File: rtl/udp_echo_responder_if.sv
// Header and byte-stream interfaces shared by udp_echo_responder and its neighbours.
// Each header interface is a valid/ready bundle; AXIS_IF carries one byte per beat with no tkeep.

interface UDP_RX_HEADER_IF;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] ip_source_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;

    modport source (
        output hdr_valid, ip_source_ip, source_port, dest_port,
        input  hdr_ready
    );
    modport sink (
        input  hdr_valid, ip_source_ip, source_port, dest_port,
        output hdr_ready
    );
endinterface

interface UDP_TX_HEADER_IF;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [7:0]  ip_ttl;
    logic [31:0] ip_source_ip;
    logic [31:0] ip_dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;

    modport source (
        output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
               source_port, dest_port, length, checksum,
        input  hdr_ready
    );
    modport sink (
        input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
               source_port, dest_port, length, checksum,
        output hdr_ready
    );
endinterface

interface AXIS_IF;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );
    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/udp_echo_responder.sv
// UDP echo responder: buffers one received datagram and sends it back to its sender
// with source and destination swapped. One packet in flight; oversize or errored packets are dropped.

module udp_echo_responder #(
    parameter int          BUFFER_DEPTH = 2048,
    parameter int unsigned TTL          = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    UDP_RX_HEADER_IF.sink          udp_rx_header_if,
    AXIS_IF.slave                  udp_rx_payload_if,
    UDP_TX_HEADER_IF.source        udp_tx_header_if,
    AXIS_IF.master                 udp_tx_payload_if,
    input  logic                   enable,
    output logic [31:0]            echo_count,
    output logic [15:0]            drop_count
);

    localparam int ADDR_W = $clog2(BUFFER_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RX_PAYLOAD = 3'd1;
    localparam logic [2:0] DROP       = 3'd2;
    localparam logic [2:0] TX_HEADER  = 3'd3;
    localparam logic [2:0] TX_PAYLOAD = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              hdr_ready_q, hdr_ready_d;
    logic [31:0]       src_ip_q, src_ip_d;
    logic [15:0]       src_port_q, src_port_d;
    logic [15:0]       dst_port_q, dst_port_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              pre_valid_q, pre_valid_d;
    logic              pre_last_q, pre_last_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [31:0]       echo_q, echo_d;
    logic [15:0]       drop_q, drop_d;

    logic [7:0]        mem [BUFFER_DEPTH];
    logic [7:0]        rd_data_q;
    logic              wr_en;
    logic              rd_en;
    logic              out_load;

    logic              rx_tready;
    logic              rx_hdr_hs;
    logic              rx_beat;
    logic              tx_hdr_hs;
    logic              tx_beat;
    logic              in_tx;

    assign rx_tready = (state_q == RX_PAYLOAD) || (state_q == DROP);
    assign rx_hdr_hs = udp_rx_header_if.hdr_valid && hdr_ready_q;
    assign rx_beat   = udp_rx_payload_if.tvalid && rx_tready;
    assign tx_hdr_hs = (state_q == TX_HEADER) && udp_tx_header_if.hdr_ready;
    assign tx_beat   = out_valid_q && udp_tx_payload_if.tready;
    assign in_tx     = (state_q == TX_HEADER) || (state_q == TX_PAYLOAD);

    // The prefetch slot (rd_data_q/pre_valid_q) refills in the same cycle it hands its byte
    // to the output register, so a continuously ready sink sees one byte per clock.
    assign out_load = (state_q == TX_PAYLOAD) && pre_valid_q && (!out_valid_q || tx_beat);
    assign rd_en    = in_tx && (rd_cnt_q != len_q) && (!pre_valid_q || out_load);

    always_comb begin
        // NOTE: every signal gets a default here first, so no path through the case leaves a latch.
        state_d     = state_q;
        src_ip_d    = src_ip_q;
        src_port_d  = src_port_q;
        dst_port_d  = dst_port_q;
        wr_cnt_d    = wr_cnt_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        echo_d      = echo_q;
        drop_d      = drop_q;
        wr_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_hdr_hs) begin
                    src_ip_d   = udp_rx_header_if.ip_source_ip;
                    src_port_d = udp_rx_header_if.source_port;
                    dst_port_d = udp_rx_header_if.dest_port;
                    wr_cnt_d   = '0;
                    state_d    = enable ? RX_PAYLOAD : DROP;
                end
            end
            RX_PAYLOAD: begin
                if (rx_beat) begin
                    wr_en = 1'b1;
                    if (udp_rx_payload_if.tlast) begin
                        if (udp_rx_payload_if.tuser) begin
                            drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                            state_d = IDLE;
                        end else begin
                            len_d    = CNT_W'(wr_cnt_q) + CNT_ONE;
                            rd_cnt_d = '0;
                            state_d  = TX_HEADER;
                        end
                    end else if (wr_cnt_q == LAST_ADDR) begin
                        state_d = DROP;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (rx_beat && udp_rx_payload_if.tlast) begin
                    drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    state_d = IDLE;
                end
            end
            TX_HEADER: begin
                if (tx_hdr_hs) begin
                    state_d = TX_PAYLOAD;
                end
            end
            TX_PAYLOAD: begin
                if (tx_beat && out_last_q) begin
                    echo_d  = echo_q + 32'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
    end

    // Prefetch slot and output register of the transmit stream.
    always_comb begin
        pre_valid_d = pre_valid_q;
        pre_last_d  = pre_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (rd_en) begin
            pre_valid_d = 1'b1;
            pre_last_d  = (rd_cnt_q == len_q - CNT_ONE);
        end else if (out_load) begin
            pre_valid_d = 1'b0;
        end

        if (out_load) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            out_last_d  = pre_last_q;
        end else if (tx_beat) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // hdr_ready is registered so it stays low while reset is held and rises on the first edge after.
    assign hdr_ready_d = (state_d == IDLE);

    // NOTE: sequential state uses non-blocking assignments only; the _d values are all computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hdr_ready_q <= 1'b0;
            src_ip_q    <= '0;
            src_port_q  <= '0;
            dst_port_q  <= '0;
            wr_cnt_q    <= '0;
            len_q       <= '0;
            rd_cnt_q    <= '0;
            pre_valid_q <= 1'b0;
            pre_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            echo_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_ready_q <= hdr_ready_d;
            src_ip_q    <= src_ip_d;
            src_port_q  <= src_port_d;
            dst_port_q  <= dst_port_d;
            wr_cnt_q    <= wr_cnt_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            pre_valid_q <= pre_valid_d;
            pre_last_q  <= pre_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            echo_q      <= echo_d;
            drop_q      <= drop_d;
        end
    end

    // NOTE: the payload RAM and its read register are deliberately not reset; every byte read
    // back was written earlier in the same packet, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt_q] <= udp_rx_payload_if.tdata;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
        end
    end

    assign udp_rx_header_if.hdr_ready = hdr_ready_q;
    assign udp_rx_payload_if.tready   = rx_tready;

    assign udp_tx_header_if.hdr_valid    = (state_q == TX_HEADER);
    assign udp_tx_header_if.ip_dscp      = '0;
    assign udp_tx_header_if.ip_ecn       = '0;
    assign udp_tx_header_if.ip_ttl       = 8'(TTL);
    assign udp_tx_header_if.ip_source_ip = '0;
    assign udp_tx_header_if.ip_dest_ip   = src_ip_q;
    assign udp_tx_header_if.source_port  = dst_port_q;
    assign udp_tx_header_if.dest_port    = src_port_q;
    assign udp_tx_header_if.length       = 16'(len_q) + 16'd8;
    assign udp_tx_header_if.checksum     = '0;

    assign udp_tx_payload_if.tvalid = out_valid_q;
    assign udp_tx_payload_if.tdata  = out_data_q;
    assign udp_tx_payload_if.tlast  = out_last_q;
    assign udp_tx_payload_if.tuser  = 1'b0;

    assign echo_count = echo_q;
    assign drop_count = drop_q;

endmodule
